// File: rtl/hazard_pkg.sv
// Shared types and strobe presets for the RV32I pipeline hazard controller.
package hazard_pkg;

    localparam int unsigned REG_AW = 5;

    typedef enum logic {
        HZ_RUN  = 1'b0,
        HZ_WAIT = 1'b1
    } hz_state_e;

    // Per-stage enable/flush strobes driven to the pipeline registers.
    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic if_id_flush;
        logic id_ex_en;
        logic id_ex_flush;
        logic ex_mem_en;
        logic mem_wb_flush;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t PIPE_RUN = '{
        pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b0, id_ex_en: 1'b1,
        id_ex_flush: 1'b0, ex_mem_en: 1'b1, mem_wb_flush: 1'b0
    };

    localparam pipe_ctrl_t PIPE_RESET = '{
        pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b1, id_ex_en: 1'b0,
        id_ex_flush: 1'b1, ex_mem_en: 1'b0, mem_wb_flush: 1'b1
    };

    // Everything up to MEM frozen; WB receives bubbles until the access completes.
    localparam pipe_ctrl_t PIPE_MEMWAIT = '{
        pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0, id_ex_en: 1'b0,
        id_ex_flush: 1'b0, ex_mem_en: 1'b0, mem_wb_flush: 1'b1
    };

    localparam pipe_ctrl_t PIPE_MISPREDICT = '{
        pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b1, id_ex_en: 1'b1,
        id_ex_flush: 1'b1, ex_mem_en: 1'b1, mem_wb_flush: 1'b0
    };

    // Hold PC and IF/ID, push a bubble into EX while the load advances.
    localparam pipe_ctrl_t PIPE_LOADUSE = '{
        pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0, id_ex_en: 1'b1,
        id_ex_flush: 1'b1, ex_mem_en: 1'b1, mem_wb_flush: 1'b0
    };

    function automatic logic load_use_hit(
        input logic              ex_load,
        input logic [REG_AW-1:0] ex_rd,
        input logic [REG_AW-1:0] rs1,
        input logic              rs1_used,
        input logic [REG_AW-1:0] rs2,
        input logic              rs2_used
    );
        return ex_load && (ex_rd != '0) &&
               ((rs1_used && (rs1 == ex_rd)) || (rs2_used && (rs2 == ex_rd)));
    endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            cnt_o <= '0;
        end else if (inc_i && (cnt_o != {W{1'b1}})) begin
            cnt_o <= cnt_o + W'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use, mispredict and data-memory wait
// handling with a wait timeout and saturating stall/flush counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned TO_W        = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [REG_AW-1:0] id_rs1_addr_i,
    input  logic [REG_AW-1:0] id_rs2_addr_i,
    input  logic              id_rs1_used_i,
    input  logic              id_rs2_used_i,
    input  logic [REG_AW-1:0] ex_rd_addr_i,
    input  logic              ex_mem_rden_i,
    input  logic              ex_mispredict_i,
    input  logic              mem_req_i,
    input  logic              mem_ack_i,
    output logic              pc_en_o,
    output logic              if_id_en_o,
    output logic              if_id_flush_o,
    output logic              id_ex_en_o,
    output logic              id_ex_flush_o,
    output logic              ex_mem_en_o,
    output logic              mem_wb_flush_o,
    output logic              mem_err_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    localparam logic [TO_W-1:0] WAIT_LAST = TO_W'(MEM_TIMEOUT - 1);

    hz_state_e       state_q, state_d;
    logic [TO_W-1:0] wait_q, wait_d;
    logic            release_q, release_d;
    logic            err_set;
    logic            run_rules;
    logic            load_use;
    logic            misp_act;
    logic            stall_inc;
    pipe_ctrl_t      ctrl;

    // State, wait counter, post-timeout release flag and sticky error.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= HZ_RUN;
            wait_q    <= '0;
            release_q <= 1'b0;
            mem_err_o <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            release_q <= release_d;
            if (err_set) begin
                mem_err_o <= 1'b1;
            end
        end
    end

    // Next state and zero-latency strobes; memory wait outranks mispredict
    // which outranks load-use.
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        release_d = 1'b0;
        err_set   = 1'b0;
        run_rules = 1'b0;
        ctrl      = PIPE_RUN;
        load_use  = load_use_hit(ex_mem_rden_i, ex_rd_addr_i,
                                 id_rs1_addr_i, id_rs1_used_i,
                                 id_rs2_addr_i, id_rs2_used_i);

        unique case (state_q)
            HZ_RUN: begin
                // The cycle after a timeout lets the stuck access leave MEM.
                if (mem_req_i && !mem_ack_i && !release_q) begin
                    ctrl    = PIPE_MEMWAIT;
                    state_d = HZ_WAIT;
                    wait_d  = TO_W'(1);
                end else begin
                    run_rules = 1'b1;
                end
            end
            HZ_WAIT: begin
                if (!mem_ack_i) begin
                    ctrl = PIPE_MEMWAIT;
                    if (wait_q == WAIT_LAST) begin
                        err_set   = 1'b1;
                        state_d   = HZ_RUN;
                        release_d = 1'b1;
                    end else begin
                        wait_d = wait_q + TO_W'(1);
                    end
                end else begin
                    run_rules = 1'b1;
                    state_d   = HZ_RUN;
                end
            end
            default: begin
                state_d = HZ_RUN;
            end
        endcase

        if (run_rules) begin
            if (ex_mispredict_i) begin
                ctrl = PIPE_MISPREDICT;
            end else if (load_use) begin
                ctrl = PIPE_LOADUSE;
            end
        end

        if (rst_i) begin
            ctrl = PIPE_RESET;
        end

        misp_act  = run_rules && ex_mispredict_i && !rst_i;
        stall_inc = !rst_i && !ctrl.pc_en;
    end

    assign pc_en_o        = ctrl.pc_en;
    assign if_id_en_o     = ctrl.if_id_en;
    assign if_id_flush_o  = ctrl.if_id_flush;
    assign id_ex_en_o     = ctrl.id_ex_en;
    assign id_ex_flush_o  = ctrl.id_ex_flush;
    assign ex_mem_en_o    = ctrl.ex_mem_en;
    assign mem_wb_flush_o = ctrl.mem_wb_flush;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .clr_i (rst_i),
        .inc_i (stall_inc),
        .cnt_o (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .clr_i (rst_i),
        .inc_i (misp_act),
        .cnt_o (flush_cnt_o)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scenario bench for hazard_ctrl: expected per-cycle results are queued as
// stimulus is applied and compared against the sampled outputs.
module tb_hazard_ctrl;

    // Strobe order: pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush
    localparam logic [6:0] S_RUN  = 7'b1101010;
    localparam logic [6:0] S_RST  = 7'b0010101;
    localparam logic [6:0] S_MW   = 7'b0000001;
    localparam logic [6:0] S_MISP = 7'b1111110;
    localparam logic [6:0] S_LU   = 7'b0001110;

    typedef struct packed {
        logic [6:0] strb;
        logic       err;
        logic [3:0] stall;
        logic [3:0] flush;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst_i;
    logic [4:0] id_rs1_addr_i, id_rs2_addr_i, ex_rd_addr_i;
    logic       id_rs1_used_i, id_rs2_used_i, ex_mem_rden_i, ex_mispredict_i;
    logic       mem_req_i, mem_ack_i;
    logic       pc_en_o, if_id_en_o, if_id_flush_o, id_ex_en_o, id_ex_flush_o;
    logic       ex_mem_en_o, mem_wb_flush_o, mem_err_o;
    logic [3:0] stall_cnt_o, flush_cnt_o;

    obs_t exp_q[$];
    obs_t obs_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.CNT_W(4), .MEM_TIMEOUT(4), .TO_W(3)) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .id_rs1_addr_i   (id_rs1_addr_i),
        .id_rs2_addr_i   (id_rs2_addr_i),
        .id_rs1_used_i   (id_rs1_used_i),
        .id_rs2_used_i   (id_rs2_used_i),
        .ex_rd_addr_i    (ex_rd_addr_i),
        .ex_mem_rden_i   (ex_mem_rden_i),
        .ex_mispredict_i (ex_mispredict_i),
        .mem_req_i       (mem_req_i),
        .mem_ack_i       (mem_ack_i),
        .pc_en_o         (pc_en_o),
        .if_id_en_o      (if_id_en_o),
        .if_id_flush_o   (if_id_flush_o),
        .id_ex_en_o      (id_ex_en_o),
        .id_ex_flush_o   (id_ex_flush_o),
        .ex_mem_en_o     (ex_mem_en_o),
        .mem_wb_flush_o  (mem_wb_flush_o),
        .mem_err_o       (mem_err_o),
        .stall_cnt_o     (stall_cnt_o),
        .flush_cnt_o     (flush_cnt_o)
    );

    // One clock of stimulus: queue expectation, sample at the falling edge.
    task automatic apply(
        input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
        input logic u1, input logic u2, input logic [4:0] rd, input logic rden,
        input logic misp, input logic req, input logic ack,
        input logic [6:0] e_strb, input logic e_err,
        input logic [3:0] e_stall, input logic [3:0] e_flush
    );
        obs_t o;
        rst_i = r; id_rs1_addr_i = rs1; id_rs2_addr_i = rs2;
        id_rs1_used_i = u1; id_rs2_used_i = u2; ex_rd_addr_i = rd;
        ex_mem_rden_i = rden; ex_mispredict_i = misp;
        mem_req_i = req; mem_ack_i = ack;
        exp_q.push_back('{e_strb, e_err, e_stall, e_flush});
        @(negedge clk);
        o.strb  = {pc_en_o, if_id_en_o, if_id_flush_o, id_ex_en_o,
                   id_ex_flush_o, ex_mem_en_o, mem_wb_flush_o};
        o.err   = mem_err_o;
        o.stall = stall_cnt_o;
        o.flush = flush_cnt_o;
        obs_q.push_back(o);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [6:0] e_strb, input logic e_err,
                        input logic [3:0] e_stall, input logic [3:0] e_flush);
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e_strb, e_err, e_stall, e_flush);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        obs_t e, o;
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, S_RST, 0, 0, 0);
        apply(1, 5, 5, 1, 1, 5, 1, 1, 1, 0, S_RST, 0, 0, 0);
        idle(S_RUN, 0, 0, 0);
        idle(S_RUN, 0, 0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL reset: got strb=%b err=%b stall=%0d flush=%0d, want strb=%b err=%b stall=%0d flush=%0d",
                         o.strb, o.err, o.stall, o.flush, e.strb, e.err, e.stall, e.flush);
            end
        end
    endtask

    task automatic test_load_use();
        obs_t e, o;
        do_reset();
        apply(0, 5, 7, 1, 1, 5, 1, 0, 0, 0, S_LU,  0, 0, 0);  // lw x5 ; add x6,x5,x7
        apply(0, 5, 7, 1, 1, 0, 0, 0, 0, 0, S_RUN, 0, 1, 0);  // bubble now in EX
        idle(S_RUN, 0, 1, 0);
        apply(0, 0, 0, 1, 1, 0, 1, 0, 0, 0, S_RUN, 0, 1, 0);  // load to x0
        apply(0, 3, 9, 1, 1, 9, 1, 0, 0, 0, S_LU,  0, 1, 0);  // rs2 match
        apply(0, 3, 9, 1, 0, 9, 1, 0, 0, 0, S_RUN, 0, 2, 0);  // rs2 unused
        apply(0, 9, 0, 0, 0, 9, 1, 0, 0, 0, S_RUN, 0, 2, 0);  // rs1 unused
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL load_use: got strb=%b err=%b stall=%0d flush=%0d, want strb=%b err=%b stall=%0d flush=%0d",
                         o.strb, o.err, o.stall, o.flush, e.strb, e.err, e.stall, e.flush);
            end
        end
    endtask

    task automatic test_mispredict();
        obs_t e, o;
        do_reset();
        apply(0, 5, 7, 1, 1, 5, 1, 1, 0, 0, S_MISP, 0, 0, 0);
        idle(S_RUN, 0, 0, 1);
        apply(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, S_MISP, 0, 0, 1);
        apply(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, S_MISP, 0, 0, 2);
        idle(S_RUN, 0, 0, 3);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL mispredict: got strb=%b err=%b stall=%0d flush=%0d, want strb=%b err=%b stall=%0d flush=%0d",
                         o.strb, o.err, o.stall, o.flush, e.strb, e.err, e.stall, e.flush);
            end
        end
    endtask

    task automatic test_mem_wait();
        obs_t e, o;
        do_reset();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, S_MW,   0, 0, 0);
        apply(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, S_MW,   0, 1, 0);
        apply(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, S_MW,   0, 2, 0);
        apply(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, S_RUN,  0, 3, 0);
        apply(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, S_RUN,  0, 3, 0);  // back in RUN
        // Mispredict held through a wait is counted only once acted on.
        apply(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, S_MW,   0, 3, 0);
        apply(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, S_MW,   0, 4, 0);
        apply(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, S_MISP, 0, 5, 0);
        idle(S_RUN, 0, 5, 1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL mem_wait: got strb=%b err=%b stall=%0d flush=%0d, want strb=%b err=%b stall=%0d flush=%0d",
                         o.strb, o.err, o.stall, o.flush, e.strb, e.err, e.stall, e.flush);
            end
        end
    endtask

    task automatic test_timeout();
        obs_t e, o;
        do_reset();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, S_MW,  0, 0, 0);
        apply(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, S_MW,  0, 1, 0);
        apply(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, S_MW,  0, 2, 0);
        apply(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, S_MW,  0, 3, 0);
        apply(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, S_RUN, 1, 4, 0);  // released
        idle(S_RUN, 1, 4, 0);
        idle(S_RUN, 1, 4, 0);
        do_reset();
        idle(S_RUN, 0, 0, 0);
        // Reset in the middle of a wait must not flag an error.
        apply(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, S_MW,  0, 0, 0);
        apply(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, S_MW,  0, 1, 0);
        do_reset();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, S_RUN, 0, 0, 0);
        idle(S_RUN, 0, 0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL timeout: got strb=%b err=%b stall=%0d flush=%0d, want strb=%b err=%b stall=%0d flush=%0d",
                         o.strb, o.err, o.stall, o.flush, e.strb, e.err, e.stall, e.flush);
            end
        end
    endtask

    task automatic test_back_to_back_saturation();
        obs_t e, o;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            apply(0, 5, 0, 1, 0, 5, 1, 0, 0, 0, S_LU, 0,
                  (i > 15) ? 4'd15 : 4'(i), 0);
        end
        idle(S_RUN, 0, 15, 0);
        idle(S_RUN, 0, 15, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL saturation: got strb=%b err=%b stall=%0d flush=%0d, want strb=%b err=%b stall=%0d flush=%0d",
                         o.strb, o.err, o.stall, o.flush, e.strb, e.err, e.stall, e.flush);
            end
        end
    endtask

    initial begin
        rst_i = 1'b1;
        id_rs1_addr_i = '0; id_rs2_addr_i = '0; ex_rd_addr_i = '0;
        id_rs1_used_i = 1'b0; id_rs2_used_i = 1'b0; ex_mem_rden_i = 1'b0;
        ex_mispredict_i = 1'b0; mem_req_i = 1'b0; mem_ack_i = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_load_use();
        test_mispredict();
        test_mem_wait();
        test_timeout();
        test_back_to_back_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage RV32I core; companion to the EX-stage operand forwarding unit.
- Detects the hazards forwarding cannot resolve: load-use, branch mispredict resolved in EX, and multi-cycle data-memory access in MEM.
- Drives per-stage enable/flush strobes for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Tracks memory-wait timeout and keeps saturating stall/flush performance counters.

Parameters:
- CNT_W, 32, width of the performance counters
- MEM_TIMEOUT, 16, max consecutive MEM wait cycles before error; must be >= 2
- TO_W, 5, width of the wait counter; must satisfy 2^TO_W > MEM_TIMEOUT

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous reset, active-high
- id_rs1_addr_i  in  5  rs1 of the instruction in ID
- id_rs2_addr_i  in  5  rs2 of the instruction in ID
- id_rs1_used_i  in  1  ID instruction reads rs1
- id_rs2_used_i  in  1  ID instruction reads rs2
- ex_rd_addr_i  in  5  rd of the instruction in EX
- ex_mem_rden_i  in  1  EX instruction is a load
- ex_mispredict_i  in  1  EX branch/jump outcome differs from the 2-bit prediction
- mem_req_i  in  1  MEM instruction accesses data memory
- mem_ack_i  in  1  data memory completes the access this cycle
- pc_en_o  out  1  PC register load enable
- if_id_en_o  out  1  IF/ID register enable
- if_id_flush_o  out  1  IF/ID register clear, loads a NOP
- id_ex_en_o  out  1  ID/EX register enable
- id_ex_flush_o  out  1  ID/EX register clear, inserts a bubble
- ex_mem_en_o  out  1  EX/MEM register enable
- mem_wb_flush_o  out  1  MEM/WB register clear, inserts a bubble
- mem_err_o  out  1  sticky memory-timeout error
- stall_cnt_o  out  CNT_W  cycles with pc_en_o=0 outside reset
- flush_cnt_o  out  CNT_W  mispredict flush events

Behaviour:
- **Reset (rst_i=1, sampled at the clock edge):**
  - State goes to RUN; wait counter, mem_err_o and both counters clear to 0.
  - While rst_i is high, all outputs are forced: pc_en/if_id_en/id_ex_en/ex_mem_en = 0, if_id_flush/id_ex_flush/mem_wb_flush = 1.
  - Reset mid-wait abandons the wait and does not set mem_err_o.
- **Strobes:** combinational from inputs plus state, with zero latency. Default in RUN with no hazard: all enables = 1, all flushes = 0.
- **Priority:** memory wait > mispredict > load-use.
- **Memory wait** (mem_req_i=1, mem_ack_i=0):
  - pc_en/if_id_en/id_ex_en/ex_mem_en = 0, mem_wb_flush = 1, other flushes = 0.
  - Next state is WAIT.
- **Mispredict** (no memory wait):
  - pc_en=1 (PC loads the redirect target), if_id_flush=1, id_ex_flush=1, all enables 1.
  - flush_cnt_o increments.
  - A simultaneous load-use is ignored because the ID instruction is wrong-path.
- **Load-use:** ex_mem_rden_i=1 and ex_rd_addr_i!=0, and (id_rs1_used_i and rs1==ex_rd) or (id_rs2_used_i and rs2==ex_rd).
  - pc_en=0, if_id_en=0, id_ex_flush=1, id_ex_en=1, ex_mem_en=1.
  - Lasts exactly one cycle, because the load moves to MEM on the next cycle.
- **FSM, states RUN and WAIT:**
  - RUN -> WAIT on a memory wait; the wait counter loads 1.
  - WAIT: while mem_ack_i=0, the memory-wait strobes apply and the counter increments.
  - WAIT with mem_ack_i=1: the cycle is evaluated with RUN priority rules (mispredict/load-use may act), and next state is RUN.
  - WAIT with mem_ack_i=0 and counter == MEM_TIMEOUT-1: mem_err_o sets (sticky until reset), next state RUN, and the pipeline is released on the next cycle.
  - A mispredict held during WAIT is not counted until the cycle it is acted on. Since EX is frozen, ex_mispredict_i stays asserted through the wait.
- **Counters:**
  - stall_cnt_o +1 every non-reset cycle with pc_en_o=0.
  - flush_cnt_o +1 per acted mispredict cycle.
  - Both saturate at all-ones and never wrap.
- A load in EX with ex_rd=x0 never stalls.

Decomposition:
- **Shared package hazard_pkg:**
  - State enum hz_state_e {HZ_RUN, HZ_WAIT}.
  - Reg-address width constant REG_AW=5.
  - Struct pipe_ctrl_t bundling the seven strobes.
  - Constants PIPE_RUN, PIPE_RESET and PIPE_MEMWAIT.
- **Sub-module sat_counter** (parameter W; inputs inc_i, clr_i; output cnt_o), instantiated twice for the performance counters.

Test Plan:
- **Reset:** rst_i=1 for 2 cycles -> pc_en=0, all three flushes=1, counters=0. After release with no hazards -> pc_en=1, all enables 1.
- **Load-use:** EX `lw x5`, ID `add x6,x5,x7` (rs1_used=1) -> exactly 1 cycle of pc_en=0, if_id_en=0, id_ex_flush=1; stall_cnt=1. Same case with rd=x0 -> no stall.
- **Mispredict + load-use same cycle:** -> if_id_flush=1, id_ex_flush=1, pc_en=1, flush_cnt=1, stall_cnt unchanged.
- **Memory wait:** mem_req=1, ack low for 3 cycles then high -> 3 cycles of freeze with mem_wb_flush=1; 4th cycle all enables 1, state RUN, stall_cnt=3.
- **Timeout (MEM_TIMEOUT=4):** ack never asserts -> mem_err_o rises after the 4th wait cycle and stays 1. Pulsing rst_i clears it.
- **Saturation (CNT_W=4):** 20 load-use stalls -> stall_cnt_o holds 15.
